// File: rtl/pkt_tx_pkg.sv
// Shared constants, FSM state type and start-legality helper for the packet transmitter.
// No latency of its own; combinational helper only.
// No flow control here; the helper is evaluated only when a start is presented.
// Contents: tx_state_t, PKT_TYPE_BYTES, SYMBOL_BYTES, LEN_W, OFF_W, MIN_PACKET_LEN, ext_t, start_legal().
package pkt_tx_pkg;

  localparam int LEN_W          = 11;
  localparam int OFF_W          = 16;
  localparam int PKT_TYPE_BYTES = 4;
  localparam int SYMBOL_BYTES   = 8;
  localparam int MIN_PACKET_LEN = PKT_TYPE_BYTES + SYMBOL_BYTES;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } tx_state_t;

  // One bit wider than an offset so that offset + field size never wraps.
  typedef logic [OFF_W:0] ext_t;

  // True when both fields fit inside the packet without overlapping and the
  // length is within [MIN_PACKET_LEN, max_len].
  function automatic logic start_legal(input logic [LEN_W-1:0] len,
                                       input logic [OFF_W-1:0] pto,
                                       input logic [OFF_W-1:0] so,
                                       input ext_t             max_len);
    ext_t l;
    ext_t p;
    ext_t s;
    logic bad;
    l = ext_t'(len);
    p = ext_t'(pto);
    s = ext_t'(so);
    bad = (l < ext_t'(MIN_PACKET_LEN)) || (l > max_len)
       || (p + ext_t'(PKT_TYPE_BYTES - 1) >= l)
       || (s + ext_t'(SYMBOL_BYTES - 1) >= l)
       || ((p <= s + ext_t'(SYMBOL_BYTES - 1)) && (s <= p + ext_t'(PKT_TYPE_BYTES - 1)));
    return !bad;
  endfunction

endpackage

// File: rtl/tx_output_stage.sv
// Single-entry output register (8-bit data + last flag) with valid/ready handshake.
// Latency: one cycle from load to valid output.
// Backpressure: contents held while vld_o && !rdy_i; load_en_o tells the producer when it may load.
// Ports: clk_i, rst_i, load_i, dat_i, last_i, rdy_i in; load_en_o, vld_o, dat_o, last_o out.
module tx_output_stage (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       load_i,
  input  logic [7:0] dat_i,
  input  logic       last_i,
  input  logic       rdy_i,
  output logic       load_en_o,
  output logic       vld_o,
  output logic [7:0] dat_o,
  output logic       last_o
);

  logic       vld_q;
  logic [7:0] dat_q;
  logic       last_q;

  // Register may be overwritten when empty or when the sink takes the held byte.
  assign load_en_o = !vld_q || rdy_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_q  <= 1'b0;
      dat_q  <= 8'h00;
      last_q <= 1'b0;
    end else if (load_en_o) begin
      // Without a new byte the register simply drains.
      vld_q <= load_i;
      if (load_i) begin
        dat_q  <= dat_i;
        last_q <= last_i;
      end
    end
  end

  assign vld_o  = vld_q;
  assign dat_o  = dat_q;
  assign last_o = last_q;

endmodule

// File: rtl/order_packet_tx.sv
// Packet builder: serializes pkt_len bytes with little-endian PACKET_TYPE/SYMBOL fields at programmable offsets, payload elsewhere.
// Latency: first byte valid two cycles after start is sampled; then 1 byte/cycle; done pulses with the last-byte handshake.
// Backpressure: tx_ready low holds the output byte; pay_valid low stalls payload positions (field bytes never wait).
// Ports: clk_i, rst_i, start_i, pkt_len_i, packet_type_offset_i, symbol_offset_i, packet_type_i, symbol_i,
//        pay_data_i/pay_valid_i/pay_ready_o, tx_data_o/tx_valid_o/tx_ready_i/tx_last_o, busy_o, done_o, err_o.
module order_packet_tx
  import pkt_tx_pkg::*;
#(
  parameter int MAX_PACKET_LEN = 1500
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] pkt_len_i,
  input  logic [OFF_W-1:0] packet_type_offset_i,
  input  logic [OFF_W-1:0] symbol_offset_i,
  input  logic [31:0]      packet_type_i,
  input  logic [63:0]      symbol_i,
  input  logic [7:0]       pay_data_i,
  input  logic             pay_valid_i,
  output logic             pay_ready_o,
  output logic [7:0]       tx_data_o,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic             tx_last_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             err_o
);

  tx_state_t        state_q, state_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic             err_q, err_d;
  logic [LEN_W-1:0] len_q;
  logic [OFF_W-1:0] pto_q, so_q;
  logic [31:0]      type_q;
  logic [63:0]      sym_q;

  logic             accept;
  ext_t             idx_x, t_rel, s_rel;
  logic             in_type, in_sym, more, is_field;
  logic             load_en, load, last_byte;
  logic [7:0]       byte_d;

  // Byte selection. A negative (idx - offset) wraps to a value far above the
  // field size in 17 bits, so a single unsigned compare covers both bounds.
  always_comb begin
    idx_x     = ext_t'(idx_q);
    t_rel     = idx_x - ext_t'(pto_q);
    s_rel     = idx_x - ext_t'(so_q);
    in_type   = t_rel < ext_t'(PKT_TYPE_BYTES);
    in_sym    = s_rel < ext_t'(SYMBOL_BYTES);
    is_field  = in_type || in_sym;
    more      = idx_q < len_q;
    last_byte = idx_q == (len_q - LEN_W'(1));
    if (in_type) begin
      byte_d = type_q[{t_rel[1:0], 3'b000} +: 8];
    end else if (in_sym) begin
      byte_d = sym_q[{s_rel[2:0], 3'b000} +: 8];
    end else begin
      byte_d = pay_data_i;
    end
  end

  always_comb begin
    load        = 1'b0;
    pay_ready_o = 1'b0;
    if (state_q == ST_SEND && more && load_en) begin
      load        = is_field || pay_valid_i;
      pay_ready_o = !is_field && pay_valid_i;
    end
  end

  tx_output_stage u_out (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .load_i    (load),
    .dat_i     (byte_d),
    .last_i    (last_byte),
    .rdy_i     (tx_ready_i),
    .load_en_o (load_en),
    .vld_o     (tx_valid_o),
    .dat_o     (tx_data_o),
    .last_o    (tx_last_o)
  );

  assign done_o = tx_valid_o && tx_ready_i && tx_last_o;
  assign busy_o = state_q == ST_SEND;
  assign err_o  = err_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    err_d   = 1'b0;
    accept  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          if (start_legal(pkt_len_i, packet_type_offset_i, symbol_offset_i,
                          ext_t'(MAX_PACKET_LEN))) begin
            accept  = 1'b1;
            idx_d   = '0;
            state_d = ST_SEND;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (load) idx_d = idx_q + LEN_W'(1);
        if (done_o) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  // Configuration is captured only on an accepted start; a rejected start leaves it untouched.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      len_q  <= '0;
      pto_q  <= '0;
      so_q   <= '0;
      type_q <= '0;
      sym_q  <= '0;
    end else if (accept) begin
      len_q  <= pkt_len_i;
      pto_q  <= packet_type_offset_i;
      so_q   <= symbol_offset_i;
      type_q <= packet_type_i;
      sym_q  <= symbol_i;
    end
  end

endmodule

// File: tb/tb_order_packet_tx.sv
module tb_order_packet_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [10:0] cfg_len = '0;
  logic [15:0] cfg_pto = '0;
  logic [15:0] cfg_so = '0;
  logic [31:0] cfg_type = '0;
  logic [63:0] cfg_sym = '0;
  logic [7:0]  pay_data = '0;
  logic        pay_valid = 1'b0;
  logic        pay_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready = 1'b1;
  logic        tx_last;
  logic        busy;
  logic        done;
  logic        err;

  always #5 clk = ~clk;

  order_packet_tx #(.MAX_PACKET_LEN(1500)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .start_i              (start),
    .pkt_len_i            (cfg_len),
    .packet_type_offset_i (cfg_pto),
    .symbol_offset_i      (cfg_so),
    .packet_type_i        (cfg_type),
    .symbol_i             (cfg_sym),
    .pay_data_i           (pay_data),
    .pay_valid_i          (pay_valid),
    .pay_ready_o          (pay_ready),
    .tx_data_o            (tx_data),
    .tx_valid_o           (tx_valid),
    .tx_ready_i           (tx_ready),
    .tx_last_o            (tx_last),
    .busy_o               (busy),
    .done_o               (done),
    .err_o                (err)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  pay_mem [0:4095];
  int          pay_ptr = 0;
  int          pay_cnt = 0;
  int          out_cnt = 0;
  logic [7:0]  exp_q [$];
  bit          rdy_rand = 1'b0;
  bit          pay_rand = 1'b0;
  bit          pay_en = 1'b1;
  bit          stall_prev = 1'b0;
  logic [7:0]  stall_dat;
  logic        stall_last;
  logic [7:0]  mon_e;
  bit          mon_done;
  logic [7:0]  lit1 [0:15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
    end
  endtask

  task automatic fail_now(input string nm, input int act);
    n_cmp++;
    n_err++;
    $display("FAIL %s: got %0d, event never happened (t=%0t)", nm, act, $time);
  endtask

  // Reference: a start is legal when both fields fit and do not share a byte.
  function automatic bit model_legal(input int len, input int pto, input int so);
    if (len < 12 || len > 1500) return 1'b0;
    if (pto + 4 > len) return 1'b0;
    if (so + 8 > len) return 1'b0;
    if (pto < so + 8 && so < pto + 4) return 1'b0;
    return 1'b1;
  endfunction

  // Reference packet: field bytes little-endian, other positions take the next payload bytes in order.
  function automatic void model_build(input int len, input int pto, input int so,
                                      input logic [31:0] pt, input logic [63:0] sy);
    int k;
    k = pay_ptr;
    exp_q.delete();
    out_cnt = 0;
    for (int i = 0; i < len; i++) begin
      if (i >= pto && i < pto + 4) exp_q.push_back(8'(pt >> (8 * (i - pto))));
      else if (i >= so && i < so + 8) exp_q.push_back(8'(sy >> (8 * (i - so))));
      else begin
        exp_q.push_back(pay_mem[k % 4096]);
        k++;
      end
    end
  endfunction

  // Input driver: changes only 1 time unit after the rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      tx_ready  = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
      pay_valid = pay_en && (pay_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
      pay_data  = pay_mem[pay_ptr % 4096];
    end
  end

  // Compare process: every cycle out of reset, on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      mon_done = 1'b0;
      if (stall_prev) begin
        chk("stall_valid", tx_valid, 1);
        chk("stall_data", tx_data, stall_dat);
        chk("stall_last", tx_last, stall_last);
      end
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          fail_now("extra_byte", tx_data);
        end else begin
          mon_e = exp_q.pop_front();
          out_cnt++;
          chk("tx_data", tx_data, mon_e);
          chk("tx_last", tx_last, exp_q.size() == 0);
          mon_done = (exp_q.size() == 0);
        end
      end
      chk("done", done, mon_done);
      if (pay_ready) begin
        chk("pay_ready_without_valid", pay_valid, 1);
        pay_ptr++;
        pay_cnt++;
      end
      stall_prev = tx_valid && !tx_ready;
      stall_dat  = tx_data;
      stall_last = tx_last;
    end
  end

  // Call aligned 1 time unit after a rising edge. Accepted: returns on the falling edge after the start edge.
  // Rejected: returns aligned 1 time unit after a rising edge.
  task automatic do_start(input int len, input int pto, input int so,
                          input logic [31:0] pt, input logic [63:0] sy, output bit legal);
    legal    = model_legal(len, pto, so);
    cfg_len  = 11'(len);
    cfg_pto  = 16'(pto);
    cfg_so   = 16'(so);
    cfg_type = pt;
    cfg_sym  = sy;
    start    = 1'b1;
    if (legal) begin
      model_build(len, pto, so, pt, sy);
      pay_cnt = 0;
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("err_after_start", err, !legal);
    chk("busy_after_start", busy, legal);
    if (!legal) begin
      chk("tx_valid_after_reject", tx_valid, 0);
      @(negedge clk);
      chk("err_single_pulse", err, 0);
      chk("busy_after_reject", busy, 0);
      chk("tx_valid_after_reject2", tx_valid, 0);
      @(posedge clk);
      #1;
    end
  endtask

  // Counts cycles from start (start cycle = 0) to the done cycle; returns 1 unit after the next rising edge.
  task automatic wait_done(input int budget, output int cyc);
    cyc = 1;
    while (!done && cyc < budget) begin
      @(negedge clk);
      cyc++;
    end
    if (!done) fail_now("done_timeout", cyc);
    @(posedge clk);
    #1;
    chk("model_drained", exp_q.size(), 0);
  endtask

  task automatic run_pkt(input int len, input int pto, input int so,
                         input logic [31:0] pt, input logic [63:0] sy);
    bit legal;
    int cyc;
    do_start(len, pto, so, pt, sy, legal);
    if (legal) begin
      wait_done(4 * len + 400, cyc);
      chk("payload_count", pay_cnt, len - 12);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got time %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit legal;
    int cyc;
    int len, pto, so;

    for (int i = 0; i < 4096; i++) pay_mem[i] = (i < 4) ? 8'(8'hA0 + i) : 8'($urandom);
    lit1 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11, 8'h22, 8'h33, 8'h44,
             8'h55, 8'h66, 8'h77, 8'h88, 8'hA0, 8'hA1, 8'hA2, 8'hA3};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_tx_last", tx_last, 0);
    chk("rst_tx_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_pay_ready", pay_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // 1: basic packet, literal expectations pin the model
    do_start(16, 0, 4, 32'h44332211, 64'h8877665544332211, legal);
    for (int i = 0; i < 16; i++) chk("model_pin_basic", exp_q[i], lit1[i]);
    wait_done(100, cyc);
    chk("basic_start_to_done_cycles", cyc, 17);
    chk("basic_payload_pulses", pay_cnt, 4);
    chk("busy_cycle_after_done", busy, 0);

    // 2: same packet under random backpressure
    rdy_rand = 1'b1;
    run_pkt(16, 0, 4, 32'h44332211, 64'h8877665544332211);
    rdy_rand = 1'b0;

    // 3: payload starvation at byte 12 (fields cover bytes 0..11)
    pay_en = 1'b0;
    @(posedge clk);
    #1;
    do_start(20, 8, 0, 32'hDDCCBBAA, 64'h0F0E0D0C0B0A0908, legal);
    repeat (16) @(negedge clk);
    chk("starve_tx_valid_gap", tx_valid, 0);
    chk("starve_busy", busy, 1);
    chk("starve_remaining_bytes", exp_q.size(), 8);
    chk("starve_no_payload_taken", pay_cnt, 0);
    @(posedge clk);
    #1;
    pay_en = 1'b1;
    wait_done(400, cyc);
    chk("starve_payload_count", pay_cnt, 8);

    // 4: rejects and boundaries
    run_pkt(10, 0, 4, 32'h1, 64'h2);
    run_pkt(16, 2, 4, 32'h1, 64'h2);
    run_pkt(20, 6, 0, 32'h1, 64'h2);
    run_pkt(1501, 0, 4, 32'h1, 64'h2);
    run_pkt(11, 0, 4, 32'h1, 64'h2);
    run_pkt(12, 9, 0, 32'h1, 64'h2);
    run_pkt(16, 10, 3, 32'h1, 64'h2);
    run_pkt(12, 8, 0, 32'hA1B2C3D4, 64'h1122334455667788);
    run_pkt(16, 11, 3, 32'h01020304, 64'h0506070809101112);
    run_pkt(1500, 0, 1492, 32'hCAFEF00D, 64'hDEADBEEF01234567);

    // 5: reset mid-packet, then a full packet from byte 0
    do_start(16, 0, 4, 32'h44332211, 64'h8877665544332211, legal);
    cyc = 0;
    while (out_cnt < 5 && cyc < 100) begin
      @(posedge clk);
      #2;
      cyc++;
    end
    if (out_cnt < 5) fail_now("reset_wait_bytes", out_cnt);
    rst = 1'b1;
    #1;
    chk("midrst_tx_valid", tx_valid, 0);
    chk("midrst_tx_last", tx_last, 0);
    chk("midrst_tx_data", tx_data, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_err", err, 0);
    chk("midrst_pay_ready", pay_ready, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    run_pkt(16, 0, 4, 32'h55667788, 64'h0123456789ABCDEF);

    // 6: start while busy is ignored, then back-to-back
    do_start(16, 0, 4, 32'h99887766, 64'h1020304050607080, legal);
    @(posedge clk);
    #1;
    cfg_len = 11'd5;
    start   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_start_no_err", err, 0);
    chk("busy_start_still_busy", busy, 1);
    wait_done(200, cyc);
    chk("b2b_busy_fell", busy, 0);
    do_start(16, 0, 4, 32'h13572468, 64'hFEDCBA9876543210, legal);
    wait_done(100, cyc);
    chk("b2b_start_to_done_cycles", cyc, 17);

    // Randomized packets with random backpressure and payload gaps
    rdy_rand = 1'b1;
    pay_rand = 1'b1;
    for (int n = 0; n < 30; n++) begin
      len = $urandom_range(12, 40);
      pto = $urandom_range(0, len);
      so  = $urandom_range(0, len);
      run_pkt(len, pto, so, $urandom, {$urandom, $urandom});
    end
    rdy_rand = 1'b0;
    pay_rand = 1'b0;

    repeat (3) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
